pe_row_feeder: RTL and testbench

Sequencer that sits directly upstream of the 8-PE convolution row (`pe_8e` ×8). For one 3×3 output position over 32 input channels it fetches 36 activation words from the ifmap SRAM and 36 words from each of the eight kernel SRAMs, then drives the row. Activations go to PE0 only; the row shifts them one PE per cycle. Kernels, valid and final are skewed per PE so that each PE sees its kernel word in the same cycle as the matching activation.

---
 rtl/pe_row_feeder.sv | 183 ++++++++++++++++++
 tb/tb_pe_row_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_feeder.sv
// Sequencer feeding one 8-PE convolution row: streams 36 ifmap/kernel beats per
// output position and skews kernel, valid and final so every PE lines up with its activation.
module pe_row_feeder #(
    parameter int DATA_W        = 64,
    parameter int ADDR_W        = 11,
    parameter int NUM_PE        = 8,
    parameter int ROW_STRIDE    = 264,
    parameter int WORDS_PER_ROW = 12,
    parameter int KROWS         = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        if_base,
    input  logic [ADDR_W-1:0]        ker_base,
    output logic                     busy,
    output logic                     done,
    output logic                     if_rd,
    output logic [ADDR_W-1:0]        if_addr,
    input  logic [DATA_W-1:0]        if_rdata,
    output logic                     ker_rd,
    output logic [ADDR_W-1:0]        ker_addr,
    input  logic [NUM_PE*DATA_W-1:0] ker_rdata,
    output logic [DATA_W-1:0]        act_out,
    output logic [NUM_PE*DATA_W-1:0] ker_out,
    output logic [NUM_PE-1:0]        valid_out,
    output logic [NUM_PE-1:0]        final_out
);

    localparam int BEATS        = WORDS_PER_ROW * KROWS;
    localparam int DRAIN_CYCLES = NUM_PE + 1;
    localparam int KW           = $clog2(BEATS + 1);
    localparam int WW           = $clog2(WORDS_PER_ROW);
    localparam int DW           = $clog2(DRAIN_CYCLES);

    localparam logic [KW-1:0]     LAST_BEAT  = KW'(BEATS - 1);
    localparam logic [WW-1:0]     LAST_WORD  = WW'(WORDS_PER_ROW - 1);
    localparam logic [DW-1:0]     LAST_DRAIN = DW'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(ROW_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t state, next_state;

    logic              load;
    logic              rd_en;
    logic [KW-1:0]     beat;
    logic [WW-1:0]     word;
    logic [DW-1:0]     drain_cnt;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] ker_base_q;

    logic              rd_vld_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] act_q;
    logic [NUM_PE-1:0] v_q;
    logic [NUM_PE-1:0] f_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (beat == LAST_BEAT) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == LAST_DRAIN) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Ifmap addressing walks a kernel row word by word, then jumps one ifmap row down.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat       <= '0;
            word       <= '0;
            row_addr   <= '0;
            ker_base_q <= '0;
            drain_cnt  <= '0;
        end else begin
            if (load) begin
                beat       <= '0;
                word       <= '0;
                row_addr   <= if_base;
                ker_base_q <= ker_base;
            end else if (rd_en) begin
                beat <= beat + 1'b1;
                if (word == LAST_WORD) begin
                    word     <= '0;
                    row_addr <= row_addr + STRIDE_A;
                end else begin
                    word <= word + 1'b1;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    assign if_rd    = rd_en;
    assign ker_rd   = rd_en;
    assign if_addr  = rd_en ? (row_addr + ADDR_W'(word)) : '0;
    assign ker_addr = rd_en ? (ker_base_q + ADDR_W'(beat)) : '0;

    // Data is zeroed on capture when no read is landing, so invalid slots stay masked downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            act_q     <= '0;
            v_q       <= '0;
            f_q       <= '0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en && (beat == LAST_BEAT);
            act_q     <= rd_vld_q ? if_rdata : '0;
            v_q       <= {v_q[NUM_PE-2:0], rd_vld_q};
            f_q       <= {f_q[NUM_PE-2:0], rd_last_q};
        end
    end

    assign act_out   = act_q;
    assign valid_out = v_q;
    assign final_out = f_q;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
        logic [DATA_W-1:0] sr [0:p];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= p; j++) begin
                    sr[j] <= '0;
                end
            end else begin
                sr[0] <= rd_vld_q ? ker_rdata[p*DATA_W +: DATA_W] : '0;
                for (int j = 1; j <= p; j++) begin
                    sr[j] <= sr[j-1];
                end
            end
        end

        assign ker_out[p*DATA_W +: DATA_W] = sr[p];
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Randomized scoreboard bench for pe_row_feeder: stimulus pushes expected beats per
// stream into queues, a negedge monitor pops and compares when the DUT presents them.
`timescale 1ns/1ps
module tb_pe_row_feeder;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 11;
    localparam int NUM_PE = 8;
    localparam int DEPTH  = 2048;
    localparam int NEVER  = 1 << 30;

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic        f;
    } item_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [ADDR_W-1:0]        if_base;
    logic [ADDR_W-1:0]        ker_base;
    logic                     busy;
    logic                     done;
    logic                     if_rd;
    logic [ADDR_W-1:0]        if_addr;
    logic [DATA_W-1:0]        if_rdata;
    logic                     ker_rd;
    logic [ADDR_W-1:0]        ker_addr;
    logic [NUM_PE*DATA_W-1:0] ker_rdata;
    logic [DATA_W-1:0]        act_out;
    logic [NUM_PE*DATA_W-1:0] ker_out;
    logic [NUM_PE-1:0]        valid_out;
    logic [NUM_PE-1:0]        final_out;

    logic [63:0] if_mem [DEPTH];
    logic [63:0] k_mem  [NUM_PE][DEPTH];

    item_t addr_q [$];
    item_t act_q  [$];
    item_t ker_q  [NUM_PE][$];

    int   cyc = 0;
    logic rst_q = 1'b0;
    int   op_t = -1000;
    int   op_kill = NEVER;
    int   checks = 0;
    int   failures = 0;
    int   t0, t1, t2;

    pe_row_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .if_base   (if_base),
        .ker_base  (ker_base),
        .busy      (busy),
        .done      (done),
        .if_rd     (if_rd),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .ker_rd    (ker_rd),
        .ker_addr  (ker_addr),
        .ker_rdata (ker_rdata),
        .act_out   (act_out),
        .ker_out   (ker_out),
        .valid_out (valid_out),
        .final_out (final_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // SRAM models: one-cycle read latency, all-ones when no read is issued.
    always @(posedge clk) begin
        if_rdata <= if_rd ? if_mem[if_addr] : '1;
        for (int p = 0; p < NUM_PE; p++) begin
            ker_rdata[p*DATA_W +: DATA_W] <= ker_rd ? k_mem[p][ker_addr] : '1;
        end
    end

    function automatic bit busy_at(input int c);
        return (c >= op_t + 1) && (c <= op_t + 46) && (c <= op_kill);
    endfunction

    function automatic bit done_at(input int c);
        return (c == op_t + 46) && (c <= op_kill);
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic purge_after(input int c);
        while (addr_q.size() > 0 && addr_q[$].cyc > c) void'(addr_q.pop_back());
        while (act_q.size() > 0 && act_q[$].cyc > c) void'(act_q.pop_back());
        for (int p = 0; p < NUM_PE; p++) begin
            while (ker_q[p].size() > 0 && ker_q[p][$].cyc > c) void'(ker_q[p].pop_back());
        end
    endtask

    // Expected stream for one accepted operation, straight from the address/skew rules.
    task automatic push_op(input int t, input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] kb);
        item_t it;
        int    ia, ka;
        for (int k = 0; k < 36; k++) begin
            ia = (int'(ib) + (k / 12) * 264 + (k % 12)) % DEPTH;
            ka = (int'(kb) + k) % DEPTH;
            it.cyc = t + 1 + k;
            it.d   = 64'({ia[10:0], ka[10:0]});
            it.f   = 1'b0;
            addr_q.push_back(it);
            it.cyc = t + 3 + k;
            it.d   = if_mem[ia];
            act_q.push_back(it);
            for (int p = 0; p < NUM_PE; p++) begin
                it.cyc = t + 3 + p + k;
                it.d   = k_mem[p][ka];
                it.f   = (k == 35);
                ker_q[p].push_back(it);
            end
        end
        op_t    = t;
        op_kill = NEVER;
    endtask

    task automatic apply_stimulus(input logic st, input logic [ADDR_W-1:0] ib,
                                  input logic [ADDR_W-1:0] kb, input logic rst);
        start    = st;
        if_base  = ib;
        ker_base = kb;
        reset    = rst;
        if (rst) begin
            op_kill = cyc;
            purge_after(cyc);
        end else if (st && !busy_at(cyc)) begin
            push_op(cyc, ib, kb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target);
        while (cyc < target) begin
            apply_stimulus(1'b0, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        bit    exp_v;
        if (cyc >= 1) begin
            if (rst_q) begin
                check_output("reset_outputs", 64'(|{busy, done, if_rd, ker_rd, valid_out, final_out,
                                                   act_out, ker_out, if_addr, ker_addr}), 64'd0);
            end
            check_output("busy", 64'(busy), 64'(busy_at(cyc)));
            check_output("done", 64'(done), 64'(done_at(cyc)));

            exp_v = addr_q.size() > 0 && addr_q[0].cyc == cyc;
            check_output("if_rd", 64'(if_rd), 64'(exp_v));
            check_output("ker_rd", 64'(ker_rd), 64'(exp_v));
            if (exp_v) begin
                it = addr_q.pop_front();
                check_output("if_addr", 64'(if_addr), 64'(it.d[21:11]));
                check_output("ker_addr", 64'(ker_addr), 64'(it.d[10:0]));
            end

            exp_v = act_q.size() > 0 && act_q[0].cyc == cyc;
            if (exp_v) begin
                it = act_q.pop_front();
                check_output("act_out", act_out, it.d);
            end else begin
                check_output("act_mask", act_out, 64'd0);
            end

            for (int p = 0; p < NUM_PE; p++) begin
                exp_v = ker_q[p].size() > 0 && ker_q[p][0].cyc == cyc;
                check_output($sformatf("valid_out[%0d]", p), 64'(valid_out[p]), 64'(exp_v));
                if (exp_v) begin
                    it = ker_q[p].pop_front();
                    check_output($sformatf("ker_out[%0d]", p), ker_out[p*DATA_W +: DATA_W], it.d);
                    check_output($sformatf("final_out[%0d]", p), 64'(final_out[p]), 64'(it.f));
                end else begin
                    check_output($sformatf("ker_mask[%0d]", p), ker_out[p*DATA_W +: DATA_W], 64'd0);
                    check_output($sformatf("final_idle[%0d]", p), 64'(final_out[p]), 64'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        if_base  = '0;
        ker_base = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if_mem[a] = 64'(a);
            for (int p = 0; p < NUM_PE; p++) begin
                k_mem[p][a] = 64'((p << 8) | a);
            end
        end

        @(posedge clk);
        #1;
        repeat (3) apply_stimulus(1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1'b1);
        repeat (2) apply_stimulus(1'b0, '0, '0, 1'b0);

        // Directed op at base 0, with stray starts at T+10 and T+46, then a back-to-back wrap op.
        t0 = cyc;
        apply_stimulus(1'b1, '0, '0, 1'b0);
        idle_until(t0 + 10);
        apply_stimulus(1'b1, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0);
        idle_until(t0 + 46);
        apply_stimulus(1'b1, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0);
        t1 = cyc;
        apply_stimulus(1'b1, 11'd2040, 11'd2040, 1'b0);

        // Mid-operation reset, then a fresh start two cycles later.
        idle_until(t1 + 47);
        t2 = cyc;
        apply_stimulus(1'b1, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0);
        idle_until(t2 + 20);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        apply_stimulus(1'b0, '0, '0, 1'b0);
        apply_stimulus(1'b1, ADDR_W'($urandom), ADDR_W'($urandom), 1'b0);
        idle_until(op_t + 48);

        for (int a = 0; a < DEPTH; a++) begin
            if_mem[a] = {$urandom, $urandom};
            for (int p = 0; p < NUM_PE; p++) begin
                k_mem[p][a] = {$urandom, $urandom};
            end
        end

        repeat (800) begin
            apply_stimulus(($urandom % 6) == 0, ADDR_W'($urandom), ADDR_W'($urandom),
                           ($urandom % 120) == 0);
        end
        repeat (60) apply_stimulus(1'b0, '0, '0, 1'b0);

        check_output("addr_q_drained", 64'(addr_q.size()), 64'd0);
        check_output("act_q_drained", 64'(act_q.size()), 64'd0);
        for (int p = 0; p < NUM_PE; p++) begin
            check_output($sformatf("ker_q_drained[%0d]", p), 64'(ker_q[p].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
